// File: rtl/mem_uart_tx.sv
// Reads a block of words from memory starting at address 0 and sends each one
// over a UART 8N1 line, least-significant byte first and LSB first within each byte.
module mem_uart_tx #(
    parameter int WORD_WIDTH   = 32,
    parameter int WORD_NUM_W   = 8,
    parameter int ADDR_W       = 8,
    parameter int CLKS_PER_BIT = 261
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memctrl_uart_send_start,
    input  logic [WORD_NUM_W-1:0] word_number,
    output logic                  mem_read_en,
    output logic [ADDR_W-1:0]     mem_read_addr,
    input  logic [WORD_WIDTH-1:0] mem_read_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int BYTES  = WORD_WIDTH / 8;
    localparam int BC_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_CAP,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t                state, next_state;
    logic [WORD_NUM_W-1:0] words_left, words_left_d;
    logic [ADDR_W-1:0]     addr, addr_d;
    logic [BC_W-1:0]       byte_cnt, byte_cnt_d;
    logic [2:0]            bit_cnt, bit_cnt_d;
    logic [BAUD_W-1:0]     baud_cnt, baud_cnt_d;
    logic [WORD_WIDTH-1:0] shreg, shreg_d;
    logic                  bit_done;
    logic                  tx_d;

    assign bit_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        words_left_d = words_left;
        addr_d       = addr;
        byte_cnt_d   = byte_cnt;
        bit_cnt_d    = bit_cnt;
        shreg_d      = shreg;
        baud_cnt_d   = '0;
        case (state)
            IDLE: begin
                if (memctrl_uart_send_start) begin
                    words_left_d = word_number;
                    addr_d       = '0;
                    next_state   = (word_number == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: next_state = RD_CAP;
            RD_CAP: begin
                shreg_d    = mem_read_data;
                byte_cnt_d = '0;
                next_state = START;
            end
            START: begin
                if (bit_done) begin
                    bit_cnt_d  = '0;
                    next_state = DATA;
                end else begin
                    baud_cnt_d = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == 3'd7) begin
                        next_state = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (byte_cnt < BC_W'(BYTES - 1)) begin
                        shreg_d    = shreg >> 8;
                        byte_cnt_d = byte_cnt + BC_W'(1);
                        next_state = START;
                    end else if (words_left > WORD_NUM_W'(1)) begin
                        words_left_d = words_left - WORD_NUM_W'(1);
                        addr_d       = addr + ADDR_W'(1);
                        next_state   = RD_REQ;
                    end else begin
                        next_state = DONE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt + BAUD_W'(1);
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Line level is decoded from the upcoming state so the registered tx lines up with it
    always_comb begin
        tx_d = 1'b1;
        case (next_state)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[bit_cnt_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            words_left    <= '0;
            addr          <= '0;
            byte_cnt      <= '0;
            bit_cnt       <= '0;
            baud_cnt      <= '0;
            shreg         <= '0;
            tx            <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_read_en   <= 1'b0;
            mem_read_addr <= '0;
        end else begin
            words_left  <= words_left_d;
            addr        <= addr_d;
            byte_cnt    <= byte_cnt_d;
            bit_cnt     <= bit_cnt_d;
            baud_cnt    <= baud_cnt_d;
            shreg       <= shreg_d;
            tx          <= tx_d;
            busy        <= (next_state != IDLE) && (next_state != DONE);
            done        <= (next_state == DONE);
            mem_read_en <= (next_state == RD_REQ);
            if (next_state == RD_REQ) begin
                mem_read_addr <= addr_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_uart_tx.sv
// Directed bench for mem_uart_tx: a memory model feeds the reader and a UART
// receiver model decodes tx; frame timing, addresses and done timing are checked.
module tb_mem_uart_tx;

    localparam int C = 13;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  word_number = 8'd0;
    logic        mem_read_en;
    logic [7:0]  mem_read_addr;
    logic [31:0] mem_read_data = 32'h0;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:15];

    int checks = 0;
    int fails = 0;
    int pos_cnt = 0;

    int en_cnt, done_cnt, done_stamp, tx_low_cnt, busy_cnt, stop_bad;
    int en_stamp_q[$];
    int addr_q[$];
    int fall_q[$];
    logic [7:0] rx_q[$];
    bit rx_act = 1'b0;
    int rx_cnt = 0;
    logic [7:0] rx_byte = 8'h0;
    logic tx_prev = 1'b1;

    mem_uart_tx #(
        .WORD_WIDTH(32),
        .WORD_NUM_W(8),
        .ADDR_W(8),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memctrl_uart_send_start(start),
        .word_number(word_number),
        .mem_read_en(mem_read_en),
        .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .tx(tx),
        .busy(busy),
        .done(done)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        pos_cnt++;
    end

    // Synchronous memory: data appears the cycle after the read strobe
    initial forever begin
        @(posedge clk);
        if (mem_read_en) mem_read_data <= mem[mem_read_addr[3:0]];
    end

    // Monitor and UART receiver, sampling mid-cycle
    initial forever begin
        @(negedge clk);
        if (mem_read_en) begin
            en_cnt++;
            en_stamp_q.push_back(pos_cnt);
            addr_q.push_back(int'(mem_read_addr));
        end
        if (done) begin
            done_cnt++;
            done_stamp = pos_cnt;
        end
        if (!tx) tx_low_cnt++;
        if (busy) busy_cnt++;
        if (!reset) begin
            rx_act = 1'b0;
        end else if (rx_act) begin
            rx_cnt++;
            if (rx_cnt >= C + C / 2 && ((rx_cnt - C / 2) % C) == 0) begin
                if ((rx_cnt - C / 2) / C <= 8) begin
                    rx_byte[(rx_cnt - C / 2) / C - 1] = tx;
                end else begin
                    if (!tx) stop_bad++;
                    rx_q.push_back(rx_byte);
                    rx_act = 1'b0;
                end
            end
        end else if (!tx && tx_prev) begin
            rx_act = 1'b1;
            rx_cnt = 0;
            fall_q.push_back(pos_cnt);
        end
        tx_prev = tx;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        en_cnt = 0;
        done_cnt = 0;
        done_stamp = -1;
        tx_low_cnt = 0;
        busy_cnt = 0;
        stop_bad = 0;
        en_stamp_q.delete();
        addr_q.delete();
        fall_q.delete();
        rx_q.delete();
    endtask

    function automatic logic [7:0] get_rx(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    function automatic int get_fall(input int i);
        if (i < fall_q.size()) return fall_q[i];
        return -1;
    endfunction

    function automatic int get_addr(input int i);
        if (i < addr_q.size()) return addr_q[i];
        return -1;
    endfunction

    function automatic int get_en_stamp(input int i);
        if (i < en_stamp_q.size()) return en_stamp_q[i];
        return -1;
    endfunction

    task automatic pulse_start(input logic [7:0] n, output int t);
        @(negedge clk);
        word_number = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = pos_cnt;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_timeout", 32'(done_cnt > 0), 32'd1);
        repeat (2 * C) @(negedge clk);
    endtask

    task automatic check_frames(input string tag, input int t, input int nwords);
        check_eq({tag, "_nbytes"}, rx_q.size(), 4 * nwords);
        check_eq({tag, "_first_fall"}, get_fall(0), t + 2);
        for (int i = 1; i < 4 * nwords; i++) begin
            check_eq({tag, "_gap"}, get_fall(i) - get_fall(i - 1),
                     (i % 4 == 0) ? 10 * C + 2 : 10 * C);
        end
        check_eq({tag, "_stop"}, stop_bad, 0);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_done_at"}, done_stamp, t + nwords * (40 * C + 2));
        check_eq({tag, "_reads"}, en_cnt, nwords);
        for (int i = 0; i < nwords; i++) begin
            check_eq({tag, "_addr"}, get_addr(i), i);
        end
    endtask

    logic [7:0] exp4 [0:15] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h00,
                                8'h67, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    initial begin
        int t;
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        // Reset and idle
        clear_mon();
        repeat (5) @(negedge clk);
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_en", mem_read_en, 1'b0);
        check_eq("rst_addr", mem_read_addr, 8'h00);
        reset = 1'b1;
        clear_mon();
        repeat (1000) @(negedge clk);
        check_eq("idle_en", en_cnt, 0);
        check_eq("idle_txlow", tx_low_cnt, 0);
        check_eq("idle_done", done_cnt, 0);
        check_eq("idle_busy", busy_cnt, 0);

        // One word
        mem[0] = 32'h44332211;
        clear_mon();
        pulse_start(8'd1, t);
        check_eq("w1_busy", busy, 1'b1);
        wait_done(45 * C + 50);
        check_eq("w1_en_at", get_en_stamp(0), t);
        check_frames("w1", t, 1);
        check_eq("w1_b0", get_rx(0), 8'h11);
        check_eq("w1_b1", get_rx(1), 8'h22);
        check_eq("w1_b2", get_rx(2), 8'h33);
        check_eq("w1_b3", get_rx(3), 8'h44);
        check_eq("w1_busy_end", busy, 1'b0);
        check_eq("w1_tx_end", tx, 1'b1);

        // Four words
        mem[0] = 32'hA5A5A5A5;
        mem[1] = 32'h0000FFFF;
        mem[2] = 32'h01234567;
        mem[3] = 32'hFFFFFFFF;
        clear_mon();
        pulse_start(8'd4, t);
        wait_done(4 * (45 * C) + 50);
        check_frames("w4", t, 4);
        for (int i = 0; i < 16; i++) check_eq("w4_byte", get_rx(i), exp4[i]);

        // Zero words
        clear_mon();
        pulse_start(8'd0, t);
        repeat (10) @(negedge clk);
        check_eq("w0_done_cnt", done_cnt, 1);
        check_eq("w0_done_soon", 32'(done_stamp >= t && done_stamp <= t + 2), 32'd1);
        check_eq("w0_reads", en_cnt, 0);
        check_eq("w0_txlow", tx_low_cnt, 0);
        check_eq("w0_busy", busy_cnt, 0);

        // Start while busy is ignored
        mem[0] = 32'hDEADBEEF;
        mem[1] = 32'hCAFEF00D;
        mem[2] = 32'h5A5A5A5A;
        clear_mon();
        pulse_start(8'd2, t);
        repeat (5 * C) @(negedge clk);
        pulse_start(8'd3, n);
        wait_done(2 * (45 * C) + 50);
        repeat (100) @(negedge clk);
        check_frames("ign", t, 2);
        check_eq("ign_b0", get_rx(0), 8'hEF);
        check_eq("ign_b3", get_rx(3), 8'hDE);
        check_eq("ign_b4", get_rx(4), 8'h0D);
        check_eq("ign_b7", get_rx(7), 8'hCA);

        // Reset during the data bits of the second byte
        mem[0] = 32'h12345678;
        mem[1] = 32'h9ABCDEF0;
        clear_mon();
        pulse_start(8'd2, t);
        n = 0;
        while (fall_q.size() < 2 && n < 30 * C) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_mid_fall_seen", 32'(fall_q.size() >= 2), 32'd1);
        repeat (4 * C) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_tx", tx, 1'b1);
        check_eq("rst_mid_busy", busy, 1'b0);
        check_eq("rst_mid_bytes", rx_q.size(), 1);
        check_eq("rst_mid_b0", get_rx(0), 8'h78);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clear_mon();
        repeat (20 * C) @(negedge clk);
        check_eq("rst_mid_done", done_cnt, 0);
        check_eq("rst_mid_txlow", tx_low_cnt, 0);
        check_eq("rst_mid_reads", en_cnt, 0);

        // Clean transfer after the reset
        mem[0] = 32'hA1B2C3D4;
        clear_mon();
        pulse_start(8'd1, t);
        wait_done(45 * C + 50);
        check_frames("post", t, 1);
        check_eq("post_b0", get_rx(0), 8'hD4);
        check_eq("post_b1", get_rx(1), 8'hC3);
        check_eq("post_b2", get_rx(2), 8'hB2);
        check_eq("post_b3", get_rx(3), 8'hA1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
